// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU writeback stage: widths, function codes,
// FSM state encoding and opcode decode helpers. The ALU imports the same codes.
package alu_writeback_pkg;

    localparam int unsigned DSIZE = 32;
    localparam int unsigned DW    = DSIZE / 2;
    localparam int unsigned FSIZE = 4;
    localparam int unsigned RSIZE = 4;

    localparam logic [RSIZE-1:0] HI_REG = 4'hF;

    localparam logic [FSIZE-1:0] FC_MUL = 4'b0001;
    localparam logic [FSIZE-1:0] FC_DIV = 4'b0010;
    localparam logic [FSIZE-1:0] FC_ROL = 4'b1000;
    localparam logic [FSIZE-1:0] FC_ROR = 4'b1001;
    localparam logic [FSIZE-1:0] FC_SHL = 4'b1010;
    localparam logic [FSIZE-1:0] FC_SHR = 4'b1011;
    localparam logic [FSIZE-1:0] FC_OR  = 4'b1100;
    localparam logic [FSIZE-1:0] FC_AND = 4'b1101;
    localparam logic [FSIZE-1:0] FC_SUB = 4'b1110;
    localparam logic [FSIZE-1:0] FC_ADD = 4'b1111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWrLo = 2'd1,
        StWrHi = 2'd2
    } wb_state_e;

    // All codes with the top bit set are single-write ops; mult and div are
    // the only defined codes below that.
    function automatic logic is_defined(input logic [FSIZE-1:0] func);
        return func[FSIZE-1] || (func == FC_MUL) || (func == FC_DIV);
    endfunction

    // Ops that need a second write of VALUE1 to HI_REG. An invalid divide
    // writes nothing at all, so it is not a pair op.
    function automatic logic is_pair_op(input logic [FSIZE-1:0] func,
                                        input logic             invalid);
        return (func == FC_MUL) || ((func == FC_DIV) && !invalid);
    endfunction

    // Ops whose first (VALUE0) write actually reaches the register file.
    function automatic logic is_write_op(input logic [FSIZE-1:0] func,
                                         input logic             invalid);
        return is_defined(func) && !((func == FC_DIV) && invalid);
    endfunction

    // Only add and sub report a meaningful OVERFLOW.
    function automatic logic is_ovf_op(input logic [FSIZE-1:0] func);
        return (func == FC_ADD) || (func == FC_SUB);
    endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// ALU result channel: valid/ready handshake plus the result payload.
interface alu_writeback_if;
    import alu_writeback_pkg::*;

    logic             valid;
    logic             ready;
    logic [FSIZE-1:0] func_code;
    logic [RSIZE-1:0] dest_reg;
    logic [DW-1:0]    value0;
    logic [DW-1:0]    value1;
    logic             overflow;
    logic             invalid;

    // ALU side
    modport master (
        output valid,
        output func_code,
        output dest_reg,
        output value0,
        output value1,
        output overflow,
        output invalid,
        input  ready
    );

    // Writeback stage side
    modport slave (
        input  valid,
        input  func_code,
        input  dest_reg,
        input  value0,
        input  value1,
        input  overflow,
        input  invalid,
        output ready
    );

endinterface

// File: rtl/alu_wb_flags.sv
// Sticky exception flags for the writeback stage. Set events arrive on the
// accepting edge, so flags and the exception pulse appear in the same cycle
// as the corresponding register-file write slot. Set beats clear.
module alu_wb_flags (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic ovf_set_i,
    input  logic inv_set_i,
    input  logic und_set_i,
    output logic ovf_flag_o,
    output logic inv_flag_o,
    output logic und_flag_o,
    output logic exc_pulse_o
);

    logic ovf_q, ovf_d;
    logic inv_q, inv_d;
    logic und_q, und_d;
    logic exc_q, exc_d;

    // Next-state: set has priority over the synchronous clear.
    always_comb begin
        ovf_d = ovf_set_i | (ovf_q & ~clr_i);
        inv_d = inv_set_i | (inv_q & ~clr_i);
        und_d = und_set_i | (und_q & ~clr_i);
        exc_d = inv_set_i | und_set_i;
    end

    // Flag and pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
            inv_q <= 1'b0;
            und_q <= 1'b0;
            exc_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            inv_q <= inv_d;
            und_q <= und_d;
            exc_q <= exc_d;
        end
    end

    assign ovf_flag_o  = ovf_q;
    assign inv_flag_o  = inv_q;
    assign und_flag_o  = und_q;
    assign exc_pulse_o = exc_q;

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage. Accepts one ALU result per handshake and commits it to
// the single register-file write port one cycle later. Mult and valid div
// take a second slot to write VALUE1 into HI_REG; the stage stalls the ALU
// during the first slot of such an op.
module alu_writeback
    import alu_writeback_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    alu_writeback_if.slave   alu_if,
    input  logic             flag_clr_i,
    output logic             rf_we_o,
    output logic [RSIZE-1:0] rf_waddr_o,
    output logic [DW-1:0]    rf_wdata_o,
    output logic             ovf_flag_o,
    output logic             inv_flag_o,
    output logic             und_flag_o,
    output logic             exc_pulse_o
);

    wb_state_e        state_q, state_d;
    logic             pair_q, pair_d;
    logic [DW-1:0]    hi_val_q, hi_val_d;
    logic             rf_we_q, rf_we_d;
    logic [RSIZE-1:0] rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]    rf_wdata_q, rf_wdata_d;

    logic transfer;
    logic ovf_set;
    logic inv_set;
    logic und_set;

    // Ready is combinational: only the first slot of a pair op blocks.
    always_comb begin
        alu_if.ready = !((state_q == StWrLo) && pair_q);
    end

    assign transfer = alu_if.valid & alu_if.ready;

    // Exception events decoded from the result being accepted this cycle.
    always_comb begin
        ovf_set = transfer & is_ovf_op(alu_if.func_code) & alu_if.overflow;
        inv_set = transfer & (alu_if.func_code == FC_DIV) & alu_if.invalid;
        und_set = transfer & ~is_defined(alu_if.func_code);
    end

    // Next state and next register-file outputs. Address and data hold
    // whenever no write is scheduled.
    always_comb begin
        state_d    = state_q;
        pair_d     = pair_q;
        hi_val_d   = hi_val_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        if ((state_q == StWrLo) && pair_q) begin
            // Second slot of mult/div; no transfer possible this cycle.
            state_d    = StWrHi;
            pair_d     = 1'b0;
            rf_we_d    = 1'b1;
            rf_waddr_d = HI_REG;
            rf_wdata_d = hi_val_q;
        end else if (transfer) begin
            state_d  = StWrLo;
            pair_d   = is_pair_op(alu_if.func_code, alu_if.invalid);
            hi_val_d = alu_if.value1;
            if (is_write_op(alu_if.func_code, alu_if.invalid)) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = alu_if.dest_reg;
                rf_wdata_d = alu_if.value0;
            end
        end else begin
            state_d = StIdle;
            pair_d  = 1'b0;
        end
    end

    // FSM, capture and registered write-port outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            pair_q     <= 1'b0;
            hi_val_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            pair_q     <= pair_d;
            hi_val_q   <= hi_val_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;

    alu_wb_flags u_flags (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (flag_clr_i),
        .ovf_set_i   (ovf_set),
        .inv_set_i   (inv_set),
        .und_set_i   (und_set),
        .ovf_flag_o  (ovf_flag_o),
        .inv_flag_o  (inv_flag_o),
        .und_flag_o  (und_flag_o),
        .exc_pulse_o (exc_pulse_o)
    );

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback with hand-computed expected values.
module tb_alu_writeback;
    import alu_writeback_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flag_clr;
    logic             rf_we;
    logic [RSIZE-1:0] rf_waddr;
    logic [DW-1:0]    rf_wdata;
    logic             ovf_flag;
    logic             inv_flag;
    logic             und_flag;
    logic             exc_pulse;

    int vectors = 0;
    int errs    = 0;

    alu_writeback_if bus ();

    alu_writeback dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .alu_if      (bus),
        .flag_clr_i  (flag_clr),
        .rf_we_o     (rf_we),
        .rf_waddr_o  (rf_waddr),
        .rf_wdata_o  (rf_wdata),
        .ovf_flag_o  (ovf_flag),
        .inv_flag_o  (inv_flag),
        .und_flag_o  (und_flag),
        .exc_pulse_o (exc_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] f, input logic [3:0] d,
                         input logic [15:0] v0, input logic [15:0] v1,
                         input logic ovf, input logic inv);
        bus.valid     = v;
        bus.func_code = f;
        bus.dest_reg  = d;
        bus.value0    = v0;
        bus.value1    = v1;
        bus.overflow  = ovf;
        bus.invalid   = inv;
    endtask

    initial begin
        rst_n    = 1'b0;
        flag_clr = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        tick();

        // Reset state
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_flags", {ovf_flag, inv_flag, und_flag, exc_pulse}, 0);
        chk("rst_ready", bus.ready, 1);
        rst_n = 1'b1;
        tick();

        // Add, no overflow: write in the next cycle only
        drive(1'b1, FC_ADD, 4'd3, 16'h0005, 16'h0000, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("add_we", rf_we, 1);
        chk("add_waddr", rf_waddr, 3);
        chk("add_wdata", rf_wdata, 16'h0005);
        tick();
        chk("add_we_off", rf_we, 0);
        chk("add_hold", {rf_waddr, rf_wdata}, {4'd3, 16'h0005});
        chk("add_flags", {ovf_flag, inv_flag, und_flag, exc_pulse}, 0);

        // Mult: lo then hi, stalled during the lo slot
        drive(1'b1, FC_MUL, 4'd2, 16'h5678, 16'h1234, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("mul_lo", {rf_we, rf_waddr, rf_wdata}, {1'b1, 4'd2, 16'h5678});
        chk("mul_ready_lo", bus.ready, 0);
        tick();
        chk("mul_hi", {rf_we, rf_waddr, rf_wdata}, {1'b1, 4'hF, 16'h1234});
        chk("mul_ready_hi", bus.ready, 1);
        tick();
        chk("mul_done", rf_we, 0);

        // Back-to-back OR then AND
        drive(1'b1, FC_OR, 4'd1, 16'h00FF, 16'h0000, 1'b0, 1'b0);
        chk("or_ready", bus.ready, 1);
        tick();
        drive(1'b1, FC_AND, 4'd4, 16'h000F, 16'h0000, 1'b0, 1'b0);
        chk("or_wr", {rf_we, rf_waddr, rf_wdata}, {1'b1, 4'd1, 16'h00FF});
        chk("and_ready", bus.ready, 1);
        tick();
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("and_wr", {rf_we, rf_waddr, rf_wdata}, {1'b1, 4'd4, 16'h000F});
        chk("and_ready_after", bus.ready, 1);
        tick();
        chk("and_done", rf_we, 0);

        // Invalid divide: no write, sticky flag, single pulse
        drive(1'b1, FC_DIV, 4'd5, 16'hAAAA, 16'hBBBB, 1'b0, 1'b1);
        tick();
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("div_inv_we", rf_we, 0);
        chk("div_inv_flag", inv_flag, 1);
        chk("div_inv_exc", exc_pulse, 1);
        chk("div_inv_ready", bus.ready, 1);
        tick();
        chk("div_inv_we2", rf_we, 0);
        chk("div_inv_exc2", exc_pulse, 0);
        chk("div_inv_sticky", inv_flag, 1);
        chk("div_inv_hold", {rf_waddr, rf_wdata}, {4'd4, 16'h000F});
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        chk("inv_clr", inv_flag, 0);

        // Sub with overflow: still written, flag set
        drive(1'b1, FC_SUB, 4'd6, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
        tick();
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("sub_wr", {rf_we, rf_waddr, rf_wdata}, {1'b1, 4'd6, 16'h7FFF});
        chk("sub_ovf", ovf_flag, 1);
        chk("sub_exc", exc_pulse, 0);
        tick();
        chk("ovf_sticky", ovf_flag, 1);
        // Set and clear together: set wins
        drive(1'b1, FC_ADD, 4'd7, 16'h1234, 16'h0000, 1'b1, 1'b0);
        flag_clr = 1'b1;
        tick();
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("ovf_set_wins", ovf_flag, 1);
        chk("add7_wr", {rf_we, rf_waddr, rf_wdata}, {1'b1, 4'd7, 16'h1234});
        tick();
        flag_clr = 1'b0;
        chk("ovf_clr", ovf_flag, 0);
        // OVERFLOW ignored for non add/sub codes
        drive(1'b1, FC_OR, 4'd8, 16'h0F0F, 16'h0000, 1'b1, 1'b0);
        tick();
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("or_ovf_ignored", ovf_flag, 0);
        chk("or_ovf_wr", {rf_we, rf_waddr, rf_wdata}, {1'b1, 4'd8, 16'h0F0F});
        tick();

        // Valid divide: quotient then remainder, then a queued OR after WR_HI
        drive(1'b1, FC_DIV, 4'd3, 16'h0007, 16'h0001, 1'b0, 1'b0);
        tick();
        drive(1'b1, FC_OR, 4'hA, 16'hC3C3, 16'h0000, 1'b0, 1'b0);
        chk("div_lo", {rf_we, rf_waddr, rf_wdata}, {1'b1, 4'd3, 16'h0007});
        chk("div_ready_lo", bus.ready, 0);
        tick();
        chk("div_hi", {rf_we, rf_waddr, rf_wdata}, {1'b1, 4'hF, 16'h0001});
        chk("div_ready_hi", bus.ready, 1);
        tick();
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("after_hi_wr", {rf_we, rf_waddr, rf_wdata}, {1'b1, 4'hA, 16'hC3C3});
        tick();
        chk("after_hi_done", rf_we, 0);

        // Undefined code
        drive(1'b1, 4'b0100, 4'd9, 16'h1111, 16'h2222, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("und_we", rf_we, 0);
        chk("und_flag", und_flag, 1);
        chk("und_exc", exc_pulse, 1);
        tick();

        // Mult, then async reset in the middle of WR_HI
        drive(1'b1, FC_MUL, 4'd9, 16'h1111, 16'h2222, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("rmul_lo", {rf_we, rf_waddr, rf_wdata}, {1'b1, 4'd9, 16'h1111});
        tick();
        chk("rmul_hi", {rf_we, rf_waddr, rf_wdata}, {1'b1, 4'hF, 16'h2222});
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid_outs", {rf_we, rf_waddr, rf_wdata}, 0);
        chk("rmid_flags", {ovf_flag, inv_flag, und_flag, exc_pulse}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rpost_we", rf_we, 0);
        chk("rpost_ready", bus.ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
Stage directly downstream of the ALU. It captures ALU results through a valid/ready handshake and commits them to the single register-file write port. Mult/div results are sequenced as two writes: VALUE0 to the destination register and VALUE1 to the hi register. Overflow, invalid-divide and undefined-opcode events are recorded in sticky status flags, with a one-cycle exception pulse.

Parameters:
DSIZE, 32, instruction width; datapath is DSIZE/2 = 16 bits
FSIZE, 4, function-code width
RSIZE, 4, register-address width (16 registers)
HI_REG, 4'hF, register receiving VALUE1 of mult (upper product) and div (remainder)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
IN_VALID  in  1  ALU result valid this cycle
IN_READY  out  1  stage accepts this cycle; transfer = IN_VALID & IN_READY
FUNC_CODE  in  FSIZE  function code of the op that produced the result
DEST_REG  in  RSIZE  destination register address
VALUE0  in  DSIZE/2  ALU low result / quotient
VALUE1  in  DSIZE/2  ALU high result / remainder
OVERFLOW  in  1  ALU overflow, meaningful for add (1111) and sub (1110) only
INVALID  in  1  ALU invalid-divide, meaningful for div (0010) only
FLAG_CLR  in  1  synchronous clear of all sticky flags
RF_WE  out  1  register-file write enable
RF_WADDR  out  RSIZE  register-file write address
RF_WDATA  out  DSIZE/2  register-file write data
OVF_FLAG  out  1  sticky: committed add/sub overflowed
INV_FLAG  out  1  sticky: invalid divide seen
UND_FLAG  out  1  sticky: undefined function code seen
EXC_PULSE  out  1  one-cycle pulse on invalid divide or undefined code

Behaviour:
- Reset (async, RST_N=0): state IDLE; RF_WE=0, RF_WADDR=0, RF_WDATA=0, all flags 0, EXC_PULSE=0, capture registers 0. Reset mid-sequence (e.g. in WR_HI) abandons the pending hi write.
- FSM states IDLE, WR_LO, WR_HI. All outputs except IN_READY are registered.
- IN_READY = 1 in IDLE and WR_HI; in WR_LO it is 1 unless the held op is mult (0001) or valid div (0010).
- Transfer: capture FUNC_CODE, DEST_REG, VALUE0, VALUE1, OVERFLOW, INVALID; next state WR_LO. Latency is 1: RF_WE is asserted in the cycle after the transfer.
- WR_LO: RF_WE=1, RF_WADDR=DEST, RF_WDATA=VALUE0.
  - Pair op: next state WR_HI.
  - Otherwise: next state WR_LO if a new transfer occurs this cycle, else IDLE.
- WR_HI: RF_WE=1, RF_WADDR=HI_REG, RF_WDATA=VALUE1. Next state WR_LO on transfer, else IDLE.
- Throughput: 1 op/cycle for single-write ops; 1 op per 2 cycles for mult/div.
- Single-write codes: 1000, 1001, 1010, 1011, 1100, 1101, 1110, 1111.
- Div with INVALID=1: no register write in either cycle (RF_WE=0 in the WR_LO slot, no WR_HI). INV_FLAG is set and EXC_PULSE=1 in that slot.
- Undefined codes (0000, 0011-0111): no write, UND_FLAG set, EXC_PULSE=1 in the WR_LO slot.
- Add/sub with OVERFLOW=1: the result is still written, and OVF_FLAG is set in the WR_LO cycle. OVERFLOW is ignored for all other codes.
- Flags: FLAG_CLR clears them the next edge. On a simultaneous set and clear, set wins.
- DEST_REG == HI_REG on mult/div: both writes issue in order, so the final register value is VALUE1.
- When RF_WE=0, RF_WADDR and RF_WDATA hold their last values.

Decomposition:
- Shared package: FUNC_CODE constants (FC_MUL=0001, FC_DIV=0010, FC_ROL=1000, FC_ROR=1001, FC_SHL=1010, FC_SHR=1011, FC_OR=1100, FC_AND=1101, FC_SUB=1110, FC_ADD=1111), the FSM state enum, and an is_pair_op/is_defined decode function. The ALU also uses these constants.
- One sub-module is natural: alu_wb_flags (sticky flag registers with set-priority clear and EXC_PULSE generation).

Test Plan:
- Reset, then add FUNC=1111 DEST=3 VALUE0=16'h0005 OVERFLOW=0 -> next cycle RF_WE=1 WADDR=3 WDATA=0005; following cycle RF_WE=0; flags 0.
- Mult FUNC=0001 DEST=2 VALUE0=16'h5678 VALUE1=16'h1234 -> cycle 1: WADDR=2 WDATA=5678; cycle 2: WADDR=F WDATA=1234; IN_READY=0 during cycle 1.
- Back-to-back OR (DEST=1, 00FF) then AND (DEST=4, 000F) on consecutive cycles -> writes on consecutive cycles; IN_READY stays 1 throughout.
- Div FUNC=0010 INVALID=1 DEST=5 -> RF_WE never 1; INV_FLAG=1; one-cycle EXC_PULSE. Then FLAG_CLR=1 -> INV_FLAG=0 next cycle.
- Sub FUNC=1110 OVERFLOW=1 VALUE0=16'h7FFF DEST=6 -> write 7FFF to R6; OVF_FLAG=1. FLAG_CLR in the same cycle as a new overflow -> OVF_FLAG stays 1.
- Code 0100 -> no write; UND_FLAG=1. Mult followed by RST_N=0 during WR_HI -> no R15 write; all outputs 0.
